sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 18, SRAM address width.
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 Parameter WAIT_CYC, default 2, range 1..15, cycles the strobe is held low in ACCESS.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  1  access request, sampled only while ready=1.
REQ-007 wr  input  1  0 = read, 1 = write; qualified by req.
REQ-008 addr  input  ADDR_W  access address, captured on accept.
REQ-009 wdata  input  DATA_W  write data, captured on accept.
REQ-010 ready  output  1  controller idle and able to accept req.
REQ-011 done  output  1  one-cycle pulse at completion of the accepted access.
REQ-012 rdata  output  DATA_W  last read result, registered.
REQ-013 sram_addr  output  ADDR_W  SRAM address pins.
REQ-014 sram_data  inout  DATA_W  SRAM data pins.
REQ-015 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  SRAM strobes, active-low.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS, DONE.
REQ-017 Accept: IDLE and req=1 -> capture addr, wdata and wr into registers, go to SETUP; IDLE and req=0 -> stay in IDLE.
REQ-018 SETUP SHALL last exactly 1 cycle: ce_n=0, oe_n=1, we_n=1, address valid; then go to ACCESS.
REQ-019 ACCESS SHALL last exactly WAIT_CYC cycles, counted by a 4-bit down-counter loaded with WAIT_CYC-1 on SETUP exit; then go to DONE.
REQ-020 During ACCESS, read: oe_n=0; write: we_n=0; the other strobe stays 1.
REQ-021 DONE SHALL last 1 cycle: all strobes 1, done=1; then go to IDLE.
REQ-022 ready SHALL be 1 only in IDLE, so the accept-to-done latency is WAIT_CYC+2 cycles and back-to-back accesses repeat every WAIT_CYC+3 cycles.
REQ-023 sram_addr SHALL be driven from the captured register from SETUP through DONE and held stable across that whole window.
REQ-024 For writes, sram_data SHALL be driven with captured wdata from SETUP through DONE, which gives one cycle of hold after we_n rises; in all other cases sram_data SHALL be high-Z.
REQ-025 For reads, rdata SHALL load sram_data on the last ACCESS cycle and hold that value until the next read completes; writes SHALL NOT change rdata.
REQ-026 All strobes SHALL be driven from registers so they are glitch-free; no strobe is derived combinationally from clk.
REQ-027 req, wr, addr and wdata changes outside IDLE SHALL have no effect.
REQ-028 In IDLE: ce_n=oe_n=we_n=1, sram_data high-Z, done=0.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, ready=1, done=0, rdata=0, all strobes=1, sram_data high-Z and sram_addr=0, including when rst falls during ACCESS.
REQ-030 An access interrupted by reset SHALL NOT produce done, and the write it was performing is not guaranteed to complete.
REQ-031 After rst rises, the first req SHALL be accepted on the next rising edge.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, SETUP, ACCESS, DONE) and the default constants ADDR_W=18, DATA_W=16 and WAIT_CYC=2.
REQ-033 The block SHALL be a single module with no sub-module; the tristate is a conditional assignment on sram_data inside sram_ctrl.

Verification
REQ-034 Write then read: write addr=0x00012, wdata=0xBEEF, WAIT_CYC=2 -> done 4 cycles after accept, we_n low for exactly 2 cycles; then read 0x00012 -> rdata=0xBEEF, oe_n low for 2 cycles.
REQ-035 Back-to-back: req held at 1 with alternating write/read for 4 accesses -> accepts spaced 5 cycles apart, exactly 4 done pulses, no overlap between oe_n=0 and we_n=0.
REQ-036 Bus discipline: a bench model checks every cycle -> sram_data is never driven by the controller while oe_n=0, and addr/data are stable throughout every we_n=0 window.
REQ-037 Reset mid-access: rst pulsed low on the 1st ACCESS cycle of a write -> strobes read 1 and the bus is high-Z within the same cycle, no done pulse, ready=1 after release.
REQ-038 Parameter sweep: WAIT_CYC=1 and WAIT_CYC=15 with ADDR_W=20, DATA_W=32 -> latencies of 3 and 17 cycles, and data 0xDEADBEEF round-trips correctly.
REQ-039 Ignored inputs: addr changes to 0x3FFFF during ACCESS of a read at 0x00005 -> sram_addr stays 0x00005 and rdata returns the content of 0x00005.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizing for the asynchronous SRAM controller.
package sram_ctrl_pkg;

  // Controller phases: wait for a request, present address with chip
  // enable, hold the read/write strobe, then signal completion.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W   = 18;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_WAIT_CYC = 2;

  // Width of the ACCESS down-counter; bounds WAIT_CYC to 1..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/sram_ctrl.sv
// Single-access asynchronous SRAM controller.
//
// Handshake: the controller accepts a request on a rising edge where
// ready=1 and req=1; wr/addr/wdata are captured on that edge and ignored
// at all other times. done pulses for one cycle when the access has
// finished, and ready returns to 1 on the following cycle. Every SRAM pin
// (strobes, address, data enable) comes straight from a flop.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output state_t            state
);

  // ACCESS lasts WAIT_CYC cycles: the counter is loaded with WAIT_CYC-1
  // on SETUP exit and ACCESS leaves when it has reached zero.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_q;
  logic [CNT_W-1:0]  cnt;

  // The data pins are only driven for a write, from SETUP through DONE,
  // which leaves one cycle of data hold after we_n has risen.
  assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

  // Access sequencer: all strobes, address, bus enable and status flags
  // are registered here so nothing reaching the SRAM can glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      rdata     <= '0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      drive_q   <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= SETUP;
            ready     <= 1'b0;
            wr_q      <= wr;
            wdata_q   <= wdata;
            sram_addr <= addr;
            drive_q   <= wr;
            sram_ce_n <= 1'b0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          cnt       <= CNT_LOAD;
          sram_oe_n <= wr_q;
          sram_we_n <= ~wr_q;
        end
        ACCESS: begin
          if (cnt == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            // Last ACCESS cycle: read data has settled while oe_n was low.
            if (!wr_q) rdata <= sram_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
          drive_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ready     <= 1'b1;
          done      <= 1'b0;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          drive_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (default sizing, WAIT_CYC=1 and
// WAIT_CYC=15 at 20/32 bits), each attached to a small SRAM model, driven
// by directed and random accesses and checked against a word-level memory.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int N = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance stimulus and observation, padded to the widest instance
  logic        req_v   [N];
  logic        wr_v    [N];
  logic [19:0] addr_v  [N];
  logic [31:0] wdata_v [N];
  logic        ready_v [N];
  logic        done_v  [N];
  logic        ce_v    [N];
  logic        oe_v    [N];
  logic        we_v    [N];
  logic [31:0] rdata_v [N];
  logic [31:0] bus_v   [N];
  logic [19:0] saddr_v [N];
  state_t      state_v [N];
  logic [31:0] idle_pat[N];
  int          wait_of [N];
  logic [31:0] dmask   [N];
  logic [19:0] amask   [N];

  // Reference model: expected word contents and last read result
  logic [31:0] exp_mem [N][256];
  bit          exp_ok  [N][256];
  logic [31:0] last_rd [N];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", tag, got, want, $time);
  endtask

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int AW = (g == 0) ? 18 : 20;
    localparam int DW = (g == 0) ? 16 : 32;
    localparam int WC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    logic [DW-1:0] rdata_w;
    logic [AW-1:0] saddr_w;
    wire  [DW-1:0] bus;
    logic [31:0]   mem [256];
    logic          drv_en;
    logic [DW-1:0] drv_val;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic          pw = 1'b0;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req_v[g]),
      .wr        (wr_v[g]),
      .addr      (addr_v[g][AW-1:0]),
      .wdata     (wdata_v[g][DW-1:0]),
      .ready     (ready_v[g]),
      .done      (done_v[g]),
      .rdata     (rdata_w),
      .sram_addr (saddr_w),
      .sram_data (bus),
      .sram_ce_n (ce_v[g]),
      .sram_oe_n (oe_v[g]),
      .sram_we_n (we_v[g]),
      .state     (state_v[g])
    );

    assign rdata_v[g] = 32'(rdata_w);
    assign saddr_v[g] = 20'(saddr_w);
    assign bus_v[g]   = 32'(bus);

    // SRAM drives on a selected read; another bus agent drives a marker
    // while the controller is idle so any leftover drive corrupts it.
    always_comb begin
      drv_en  = 1'b0;
      drv_val = '0;
      if (!ce_v[g] && !oe_v[g]) begin
        drv_en  = 1'b1;
        drv_val = mem[saddr_w[7:0]][DW-1:0];
      end else if (ce_v[g] && ready_v[g]) begin
        drv_en  = 1'b1;
        drv_val = idle_pat[g][DW-1:0];
      end
    end
    assign bus = drv_en ? drv_val : {DW{1'bz}};

    // SRAM array write while selected with we_n low
    always @(posedge clk) begin
      if (!ce_v[g] && !we_v[g]) mem[saddr_w[7:0]] <= 32'(bus);
    end

    // Per-cycle bus discipline monitor
    always @(negedge clk) begin
      check("oe_we_overlap", 32'(!oe_v[g] && !we_v[g]), 32'd0);
      if (ce_v[g]) check("strobes_without_ce", {30'd0, oe_v[g], we_v[g]}, 32'd3);
      if (done_v[g]) check("done_strobes", {29'd0, ce_v[g], oe_v[g], we_v[g]}, 32'd7);
      if (!ce_v[g] && !oe_v[g]) check("read_bus_owner", bus_v[g], 32'(mem[saddr_w[7:0]][DW-1:0]));
      if (ce_v[g] && ready_v[g]) check("idle_bus_released", bus_v[g], 32'(idle_pat[g][DW-1:0]));
      if (!we_v[g] && pw) begin
        check("we_addr_stable", 32'(saddr_w), 32'(pa));
        check("we_data_stable", bus_v[g], 32'(pd));
      end
      pw <= !we_v[g];
      pa <= saddr_w;
      pd <= bus;
    end
  end

  // Driver: one access on instance k, starting at a negedge
  task automatic access(input int k, input bit w, input logic [19:0] a, input logic [31:0] d);
    int n, lat, oe_lo, we_lo, wc;
    logic [31:0] expv;
    wc = wait_of[k];
    n = 0;
    while (ready_v[k] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
    req_v[k]   = 1'b1;
    wr_v[k]    = w;
    addr_v[k]  = a;
    wdata_v[k] = d;
    lat = -1;
    oe_lo = 0;
    we_lo = 0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (!oe_v[k]) oe_lo++;
      if (!we_v[k]) we_lo++;
      check("sram_addr_hold", 32'(saddr_v[k]), 32'(a));
      if (done_v[k]) begin
        lat = c;
        req_v[k] = 1'b0;
      end else begin
        req_v[k]   = 1'($urandom_range(0, 1));
        wr_v[k]    = 1'($urandom_range(0, 1));
        addr_v[k]  = c[0] ? (20'h3FFFF & amask[k]) : (20'($urandom) & amask[k]);
        wdata_v[k] = $urandom & dmask[k];
      end
    end
    req_v[k] = 1'b0;
    check("latency", lat, wc + 2);
    if (w) begin
      check("we_low_cycles", we_lo, wc);
      check("oe_low_in_write", oe_lo, 0);
      check("rdata_hold_on_write", rdata_v[k], last_rd[k]);
      exp_mem[k][a[7:0]] = d & dmask[k];
      exp_ok[k][a[7:0]]  = 1'b1;
    end else begin
      check("oe_low_cycles", oe_lo, wc);
      check("we_low_in_read", we_lo, 0);
      expv = exp_mem[k][a[7:0]];
      check("rdata", rdata_v[k], expv);
      last_rd[k] = expv;
    end
    @(negedge clk);
    check("done_one_pulse", 32'(done_v[k]), 32'd0);
    check("ready_after_done", 32'(ready_v[k]), 32'd1);
  endtask

  // Driver: req held high, write/read/write/read back to back
  task automatic back_to_back(input int k);
    bit          op_w [4];
    logic [19:0] op_a [4];
    logic [31:0] op_d [4];
    int acc [4];
    int idx, dones, wc;
    wc = wait_of[k];
    op_w = '{1'b1, 1'b0, 1'b1, 1'b0};
    op_a[0] = 20'($urandom_range(64, 127));
    op_a[1] = op_a[0];
    op_a[2] = op_a[0] + 20'd1;
    op_a[3] = op_a[2];
    op_d[0] = $urandom & dmask[k];
    op_d[1] = op_d[0];
    op_d[2] = $urandom & dmask[k];
    op_d[3] = op_d[2];
    idx = 0;
    dones = 0;
    req_v[k] = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (done_v[k]) begin
        if (dones < 4 && !op_w[dones]) check("b2b_rdata", rdata_v[k], op_d[dones]);
        dones++;
      end
      if (idx < 4 && ready_v[k]) begin
        wr_v[k]    = op_w[idx];
        addr_v[k]  = op_a[idx];
        wdata_v[k] = op_w[idx] ? op_d[idx] : ($urandom & dmask[k]);
        acc[idx]   = cyc;
        idx++;
      end else begin
        if (idx == 4) req_v[k] = 1'b0;
        wr_v[k]    = 1'($urandom_range(0, 1));
        addr_v[k]  = 20'($urandom) & amask[k];
        wdata_v[k] = $urandom & dmask[k];
      end
      @(negedge clk);
    end
    req_v[k] = 1'b0;
    check("b2b_accepts", idx, 4);
    check("b2b_done_pulses", dones, 4);
    for (int i = 1; i < 4; i++) check("b2b_spacing", acc[i] - acc[i-1], wc + 3);
    for (int i = 0; i < 4; i++) begin
      if (op_w[i]) begin
        exp_mem[k][op_a[i][7:0]] = op_d[i];
        exp_ok[k][op_a[i][7:0]]  = 1'b1;
      end
    end
    last_rd[k] = op_d[3];
  endtask

  task automatic reset_checks(input int k, input string phase);
    check({phase, "_state"}, state_v[k], IDLE);
    check({phase, "_ready"}, 32'(ready_v[k]), 32'd1);
    check({phase, "_done"}, 32'(done_v[k]), 32'd0);
    check({phase, "_rdata"}, rdata_v[k], 32'd0);
    check({phase, "_sram_addr"}, 32'(saddr_v[k]), 32'd0);
    check({phase, "_strobes"}, {29'd0, ce_v[k], oe_v[k], we_v[k]}, 32'd7);
    check({phase, "_bus_released"}, bus_v[k], idle_pat[k] & dmask[k]);
  endtask

  // Reset pulse on the first ACCESS cycle of a write on instance 0
  task automatic reset_mid_access();
    int n;
    n = 0;
    while (ready_v[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    req_v[0] = 1'b1;
    wr_v[0] = 1'b1;
    addr_v[0] = 20'h00077;
    wdata_v[0] = 32'h0000A5A5;
    @(negedge clk);
    req_v[0] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      reset_checks(k, "rst_mid");
      last_rd[k] = 32'd0;
    end
    exp_ok[0][8'h77] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", 32'(done_v[0]), 32'd0);
    end
    rst = 1'b1;
    access(0, 1'b0, 20'h00012, 32'd0);
  endtask

  initial begin
    logic [19:0] a;
    logic [31:0] d;
    bit          w;
    wait_of = '{2, 1, 15};
    dmask   = '{32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    amask   = '{20'h3FFFF, 20'hFFFFF, 20'hFFFFF};
    for (int k = 0; k < N; k++) begin
      req_v[k]    = 1'b0;
      wr_v[k]     = 1'b0;
      addr_v[k]   = '0;
      wdata_v[k]  = '0;
      last_rd[k]  = '0;
      idle_pat[k] = 32'hC3A55A3C ^ (32'h01010101 * k);
      for (int i = 0; i < 256; i++) begin
        exp_mem[k][i] = '0;
        exp_ok[k][i]  = 1'b0;
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) reset_checks(k, "reset");
    rst = 1'b1;

    // Write then read at default sizing; first req right after release
    access(0, 1'b1, 20'h00012, 32'h0000BEEF);
    access(0, 1'b0, 20'h00012, 32'd0);

    // Parameter corners with 32-bit data
    access(1, 1'b1, 20'h00ABC, 32'hDEADBEEF);
    access(1, 1'b0, 20'h00ABC, 32'd0);
    access(2, 1'b1, 20'hF00C3, 32'hDEADBEEF);
    access(2, 1'b0, 20'hF00C3, 32'd0);

    // Address changes to 0x3FFFF mid-read must be ignored
    access(0, 1'b1, 20'h00005, 32'h00001234);
    access(0, 1'b0, 20'h00005, 32'd0);

    back_to_back(0);
    back_to_back(1);

    reset_mid_access();

    // Random mix; reads only target words with known content
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < ((k == 2) ? 6 : 25); i++) begin
        a = ((20'($urandom) & amask[k] & 20'hFFF00) | 20'($urandom_range(0, 31)));
        w = 1'($urandom_range(0, 1)) || !exp_ok[k][a[7:0]];
        d = $urandom & dmask[k];
        access(k, w, a, d);
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
